// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one full round per clock, keys expanded on the fly.
// Valid/ready handshakes on block input and ciphertext output.
module aes128_round_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic [3:0]   round
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m0, m1, m2, m3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        m0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        m1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        m2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        m3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {m3, m2, m1, m0};
    endfunction

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [3:0]   r_round;

    logic [7:0]   w_rcon;
    logic [31:0]  w_w3;
    logic [31:0]  w_t;
    logic [31:0]  w_nk0, w_nk1, w_nk2, w_nk3;
    logic [127:0] w_sb, w_sr, w_mc, w_state_nxt;

    always_comb begin
        w_rcon = 8'h00;
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // RotWord brings byte 1 down to byte 0 before SubWord
    always_comb begin
        w_w3 = r_rk[127:96];
        w_t  = {sbox(w_w3[7:0]), sbox(w_w3[31:24]),
                sbox(w_w3[23:16]), sbox(w_w3[15:8])} ^ {24'd0, w_rcon};
        w_nk0 = r_rk[31:0] ^ w_t;
        w_nk1 = r_rk[63:32] ^ w_nk0;
        w_nk2 = r_rk[95:64] ^ w_nk1;
        w_nk3 = r_rk[127:96] ^ w_nk2;
    end

    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int k = 0; k < 16; k++)
            w_sb[8*k +: 8] = sbox(r_state[8*k +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_sr[8*(4*c+r) +: 8] = w_sb[8*(4*((c+r)%4)+r) +: 8];
        for (int c = 0; c < 4; c++)
            w_mc[32*c +: 32] = mixcol(w_sr[32*c +: 32]);
        w_state_nxt = ((r_round == 4'd10) ? w_sr : w_mc)
                    ^ {w_nk3, w_nk2, w_nk1, w_nk0};
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_fsm_nxt = S_ROUND;
            end
            S_ROUND: begin
                if (r_round == 4'd10) w_fsm_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_round <= 4'd0;
            r_state <= '0;
            r_rk    <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            unique case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= in_block ^ in_key;
                        r_rk    <= in_key;
                        r_round <= 4'd1;
                    end
                end
                S_ROUND: begin
                    r_state <= w_state_nxt;
                    r_rk    <= {w_nk3, w_nk2, w_nk1, w_nk0};
                    if (r_round != 4'd10) r_round <= r_round + 4'd1;
                end
                S_DONE: begin
                    if (out_ready) r_round <= 4'd0;
                end
                default: r_round <= 4'd0;
            endcase
        end
    end

    assign out_block = r_state;
    assign round     = r_round;

endmodule
